// File: rtl/weight_buffer_pingpong.sv
// -----------------------------------------------------------------------------
// weight_buffer_pingpong
//
// Two-bank ping-pong weight store in front of the N_DIM_ARRAY x N_DIM_ARRAY
// MAC array. A loader fills one bank (fill_sel) while the array reads the
// other (rd_sel). Each bank is either EMPTY or FULL. fill_done and
// consume_done swap the roles of the two banks.
//
// A CNN read returns a single row with one cycle of latency. An FC read gathers
// N_DIM_ARRAY consecutive rows into a full matrix word.
//
// Ports:
//   clk, reset                clock, asynchronous active-low reset
//   enable                    freezes all state when low
//   mode                      0 = FC, 1 = CNN, others = NULL (zeros, CNN timing)
//   wr_en/wr_addr/wr_data     row write into the fill bank
//   fill_done, fill_ready     fill bank handoff / fill bank is EMPTY
//   consume_done, rd_ready    read bank release / read bank is FULL
//   rd_en/rd_addr             read request, row address
//   weight_memory_pointer     base offset added to rd_addr (wraps)
//   rd_busy, rd_valid         FC gather in flight / read_word valid pulse
//   read_word                 row i at bits [i*N*W +: N*W]
//   active_bank               index of the read bank
//   overflow_err              sticky: write side used while bank not EMPTY
//   underflow_err             sticky: read side used while bank not FULL
// -----------------------------------------------------------------------------
module weight_buffer_pingpong #(
    parameter int N_DIM_ARRAY       = 8,
    parameter int WEIGHT_DATA_WIDTH = 8,
    parameter int BANK_DEPTH        = 4096,
    // Derived from BANK_DEPTH; leave at its default.
    parameter int ADDR_W            = $clog2(BANK_DEPTH)
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               enable,
    input  logic [2:0]                                         mode,
    input  logic                                               wr_en,
    input  logic [ADDR_W-1:0]                                  wr_addr,
    input  logic [N_DIM_ARRAY*WEIGHT_DATA_WIDTH-1:0]           wr_data,
    input  logic                                               fill_done,
    output logic                                               fill_ready,
    input  logic                                               consume_done,
    input  logic                                               rd_en,
    input  logic [ADDR_W-1:0]                                  rd_addr,
    input  logic [ADDR_W-1:0]                                  weight_memory_pointer,
    output logic                                               rd_ready,
    output logic                                               rd_busy,
    output logic                                               rd_valid,
    output logic [N_DIM_ARRAY*N_DIM_ARRAY*WEIGHT_DATA_WIDTH-1:0] read_word,
    output logic                                               active_bank,
    output logic                                               overflow_err,
    output logic                                               underflow_err
);

    localparam int ROW_W  = N_DIM_ARRAY * WEIGHT_DATA_WIDTH;
    localparam int WORD_W = N_DIM_ARRAY * ROW_W;
    localparam int CNT_W  = $clog2(N_DIM_ARRAY + 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(N_DIM_ARRAY - 1);

    typedef enum logic {EMPTY, FULL} bank_state_t;

    bank_state_t          bank_state [2];
    logic                 fill_sel;
    logic                 rd_sel;
    logic                 consume_pending;
    logic [CNT_W-1:0]     gather_cnt;
    logic [ADDR_W-1:0]    gather_addr;
    logic [WORD_W-1:0]    gather_buf;
    logic [WORD_W-1:0]    gather_next;
    logic [ADDR_W-1:0]    eff_addr;
    logic [ADDR_W-1:0]    read_addr;
    logic [ROW_W-1:0]     read_row;
    logic                 accept;

    logic [ROW_W-1:0] mem0 [BANK_DEPTH];
    logic [ROW_W-1:0] mem1 [BANK_DEPTH];

    assign fill_ready  = (bank_state[fill_sel] == EMPTY);
    assign rd_ready    = (bank_state[rd_sel] == FULL);
    assign active_bank = rd_sel;

    // BANK_DEPTH is a power of two, so the natural ADDR_W-bit wrap gives the modulo.
    assign eff_addr  = rd_addr + weight_memory_pointer;
    assign read_addr = rd_busy ? gather_addr : eff_addr;
    assign read_row  = rd_sel ? mem1[read_addr] : mem0[read_addr];

    // While a released bank waits for its swap, new reads are held off so that
    // nothing is started on a bank that is about to become EMPTY.
    assign accept = enable && rd_en && rd_ready && !rd_busy && !consume_pending;

    // Gather word with the row fetched this cycle merged into its slot.
    always_comb begin
        gather_next = gather_buf;
        gather_next[int'(gather_cnt)*ROW_W +: ROW_W] = read_row;
    end

    // Row storage. Only the fill bank is ever written, and it is never the
    // read bank while EMPTY/FULL rules hold, so there is no read/write hazard.
    always_ff @(posedge clk) begin
        if (enable && wr_en && fill_ready) begin
            if (fill_sel) begin
                mem1[wr_addr] <= wr_data;
            end else begin
                mem0[wr_addr] <= wr_data;
            end
        end
    end

    // Bank handshake, error flags and the read/gather pipeline. fill_done and
    // consume_done always act on different banks, so both may update at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_state[0]   <= EMPTY;
            bank_state[1]   <= EMPTY;
            fill_sel        <= 1'b0;
            rd_sel          <= 1'b0;
            consume_pending <= 1'b0;
            gather_cnt      <= '0;
            gather_addr     <= '0;
            gather_buf      <= '0;
            rd_busy         <= 1'b0;
            rd_valid        <= 1'b0;
            read_word       <= '0;
            overflow_err    <= 1'b0;
            underflow_err   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (enable) begin
                if (wr_en && !fill_ready) begin
                    overflow_err <= 1'b1;
                end
                if (fill_done) begin
                    if (fill_ready) begin
                        bank_state[fill_sel] <= FULL;
                        fill_sel             <= ~fill_sel;
                    end else begin
                        overflow_err <= 1'b1;
                    end
                end

                // A release seen during a gather is applied in the rd_valid
                // cycle, so the swap becomes visible right after it.
                if (consume_pending && !rd_busy) begin
                    bank_state[rd_sel] <= EMPTY;
                    rd_sel             <= ~rd_sel;
                    consume_pending    <= 1'b0;
                end else if (consume_done) begin
                    if (!rd_ready) begin
                        underflow_err <= 1'b1;
                    end else if (rd_busy) begin
                        consume_pending <= 1'b1;
                    end else begin
                        bank_state[rd_sel] <= EMPTY;
                        rd_sel             <= ~rd_sel;
                    end
                end

                if (rd_en && !rd_ready) begin
                    underflow_err <= 1'b1;
                end

                if (rd_busy) begin
                    gather_buf  <= gather_next;
                    gather_addr <= gather_addr + 1'b1;
                    gather_cnt  <= gather_cnt + 1'b1;
                    if (gather_cnt == LAST_ROW) begin
                        rd_busy   <= 1'b0;
                        rd_valid  <= 1'b1;
                        read_word <= gather_next;
                    end
                end else if (accept) begin
                    if (mode == 3'd0) begin
                        gather_buf  <= WORD_W'(read_row);
                        gather_addr <= eff_addr + 1'b1;
                        gather_cnt  <= CNT_W'(1);
                        rd_busy     <= 1'b1;
                    end else if (mode == 3'd1) begin
                        rd_valid  <= 1'b1;
                        read_word <= WORD_W'(read_row);
                    end else begin
                        rd_valid  <= 1'b1;
                        read_word <= '0;
                    end
                end
            end
        end
    end

endmodule
